// File: rtl/alimentador_produto_escalar_pkg.sv
// produto_escalar_pkg: shared sizes and FSM state encoding for the dot-product feeder
package produto_escalar_pkg;
   localparam int N_ELEM = 8;
   localparam int W_ELEM = 32;
   localparam int W_ACC  = 64;
   localparam int W_IDX  = $clog2(N_ELEM);
   typedef enum logic [1:0] {COLETA, DISPARO, ESPERA, SAIDA} estado_t;
endpackage

// File: rtl/alimentador_produto_escalar_banco_vetores.sv
// banco_vetores: 8x2 element slot registers with one write port and parallel reads
module banco_vetores
   import produto_escalar_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           we,
   input  logic [W_IDX-1:0]               idx,
   input  logic [W_ELEM-1:0]              a,
   input  logic [W_ELEM-1:0]              b,
   output logic [N_ELEM-1:0][W_ELEM-1:0]  va,
   output logic [N_ELEM-1:0][W_ELEM-1:0]  vb
);
   logic [N_ELEM-1:0][W_ELEM-1:0] a_q, a_d, b_q, b_d;

   // write the addressed slot pair, every other slot holds
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (we) begin
         a_d[idx] = a;
         b_d[idx] = b;
      end
   end

   // slot storage, cleared by the active-low synchronous reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
      end
   end

   assign va = a_q;
   assign vb = b_q;
endmodule

// File: rtl/alimentador_produto_escalar.sv
// alimentador_produto_escalar: streams 8 (a,b) pairs into the dot-product engine and returns its result
module alimentador_produto_escalar
   import produto_escalar_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [W_ELEM-1:0] in_a,
   input  logic signed [W_ELEM-1:0] in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [W_ACC-1:0]  out_data,
   output logic                     out_erro,
   output logic                     eng_start,
   output logic signed [W_ELEM-1:0] eng_a0,
   output logic signed [W_ELEM-1:0] eng_a1,
   output logic signed [W_ELEM-1:0] eng_a2,
   output logic signed [W_ELEM-1:0] eng_a3,
   output logic signed [W_ELEM-1:0] eng_a4,
   output logic signed [W_ELEM-1:0] eng_a5,
   output logic signed [W_ELEM-1:0] eng_a6,
   output logic signed [W_ELEM-1:0] eng_a7,
   output logic signed [W_ELEM-1:0] eng_b0,
   output logic signed [W_ELEM-1:0] eng_b1,
   output logic signed [W_ELEM-1:0] eng_b2,
   output logic signed [W_ELEM-1:0] eng_b3,
   output logic signed [W_ELEM-1:0] eng_b4,
   output logic signed [W_ELEM-1:0] eng_b5,
   output logic signed [W_ELEM-1:0] eng_b6,
   output logic signed [W_ELEM-1:0] eng_b7,
   input  logic                     eng_done,
   input  logic signed [W_ACC-1:0]  eng_result,
   output logic                     ocupado,
   output logic [15:0]              n_ops
);
   localparam int W_TMO = $clog2(TIMEOUT_CICLOS + 1);

   estado_t                       estado_q, estado_d;
   logic [W_IDX-1:0]              idx_q, idx_d;
   logic [W_TMO-1:0]              tmo_q, tmo_d;
   logic [W_ACC-1:0]              data_q, data_d;
   logic                          erro_q, erro_d;
   logic [15:0]                   n_ops_q, n_ops_d;
   logic                          we;
   logic [N_ELEM-1:0][W_ELEM-1:0] va, vb;

   banco_vetores u_banco (
      .clk (clk),
      .rst (rst),
      .we  (we),
      .idx (idx_q),
      .a   (in_a),
      .b   (in_b),
      .va  (va),
      .vb  (vb)
   );

   // next-state, slot write enable, timeout count and result capture
   always_comb begin
      estado_d = estado_q;
      idx_d    = idx_q;
      tmo_d    = tmo_q;
      data_d   = data_q;
      erro_d   = erro_q;
      n_ops_d  = n_ops_q;
      we       = 1'b0;
      case (estado_q)
         COLETA: begin
            if (in_valid) begin
               we    = 1'b1;
               idx_d = idx_q + 1'b1;
               if (idx_q == W_IDX'(N_ELEM - 1)) estado_d = DISPARO;
            end
         end
         DISPARO: begin
            tmo_d    = '0;
            estado_d = ESPERA;
         end
         ESPERA: begin
            if (eng_done) begin
               data_d   = eng_result;
               erro_d   = 1'b0;
               estado_d = SAIDA;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_d == W_TMO'(TIMEOUT_CICLOS)) begin
                  data_d   = '0;
                  erro_d   = 1'b1;
                  estado_d = SAIDA;
               end
            end
         end
         SAIDA: begin
            if (out_ready) begin
               n_ops_d  = n_ops_q + 16'd1;
               estado_d = COLETA;
            end
         end
         default: estado_d = COLETA;
      endcase
   end

   // control state registers, synchronous active-low reset discards any work in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         estado_q <= COLETA;
         idx_q    <= '0;
         tmo_q    <= '0;
         data_q   <= '0;
         erro_q   <= 1'b0;
         n_ops_q  <= '0;
      end else begin
         estado_q <= estado_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
         data_q   <= data_d;
         erro_q   <= erro_d;
         n_ops_q  <= n_ops_d;
      end
   end

   assign in_ready  = estado_q == COLETA;
   assign out_valid = estado_q == SAIDA;
   assign eng_start = estado_q == DISPARO;
   assign ocupado   = !(estado_q == COLETA && idx_q == '0);
   assign out_data  = data_q;
   assign out_erro  = erro_q;
   assign n_ops     = n_ops_q;
   assign eng_a0 = va[0];
   assign eng_a1 = va[1];
   assign eng_a2 = va[2];
   assign eng_a3 = va[3];
   assign eng_a4 = va[4];
   assign eng_a5 = va[5];
   assign eng_a6 = va[6];
   assign eng_a7 = va[7];
   assign eng_b0 = vb[0];
   assign eng_b1 = vb[1];
   assign eng_b2 = vb[2];
   assign eng_b3 = vb[3];
   assign eng_b4 = vb[4];
   assign eng_b5 = vb[5];
   assign eng_b6 = vb[6];
   assign eng_b7 = vb[7];
endmodule

// File: tb/tb_alimentador_produto_escalar.sv
// tb_alimentador_produto_escalar: scoreboard bench with a behavioural produto_escalar engine
module tb_alimentador_produto_escalar;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, out_erro, eng_start, ocupado;
   logic [31:0] in_a, in_b;
   logic [63:0] out_data;
   logic [15:0] n_ops;
   logic [31:0] ea[8], eb[8];
   logic        eng_done;
   logic [63:0] eng_result;
   logic        mute;
   int          ecnt;

   typedef struct {logic [63:0] d; logic e;} exp_t;
   exp_t        sb[$];
   logic [31:0] va[8], vb[8];
   int          n_vec = 0, n_err = 0;
   int          exp_ops = 0;

   always #5 clk = ~clk;

   alimentador_produto_escalar dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_erro(out_erro),
      .eng_start(eng_start),
      .eng_a0(ea[0]), .eng_a1(ea[1]), .eng_a2(ea[2]), .eng_a3(ea[3]),
      .eng_a4(ea[4]), .eng_a5(ea[5]), .eng_a6(ea[6]), .eng_a7(ea[7]),
      .eng_b0(eb[0]), .eng_b1(eb[1]), .eng_b2(eb[2]), .eng_b3(eb[3]),
      .eng_b4(eb[4]), .eng_b5(eb[5]), .eng_b6(eb[6]), .eng_b7(eb[7]),
      .eng_done(eng_done), .eng_result(eng_result),
      .ocupado(ocupado), .n_ops(n_ops)
   );

   function automatic logic [63:0] dot(input logic [31:0] a[8], input logic [31:0] b[8]);
      longint s = 0;
      for (int i = 0; i < 8; i++) s += longint'($signed(a[i])) * longint'($signed(b[i]));
      return s;
   endfunction

   // engine stand-in: done pulse 9 cycles after the start cycle, reset by ~rst like the real engine
   always @(posedge clk) begin
      if (!rst) begin
         ecnt     <= 0;
         eng_done <= 1'b0;
      end else begin
         eng_done <= 1'b0;
         if (eng_start && !mute) begin
            ecnt       <= 8;
            eng_result <= dot(ea, eb);
         end else if (ecnt != 0) begin
            ecnt <= ecnt - 1;
            if (ecnt == 1) eng_done <= 1'b1;
         end
      end
   end

   task automatic confere(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic put(input logic [31:0] a, input logic [31:0] b);
      int k = 0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      while (!in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      confere("in_ready_wait", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic load(input bit gap);
      for (int i = 0; i < 8; i++) begin
         put(va[i], vb[i]);
         if (i == 0) confere("ocupado_loading", ocupado, 1);
         if (gap && i < 7) begin
            confere("gap_in_ready", in_ready, 1);
            @(negedge clk);
         end
      end
      sb.push_back('{mute ? 64'd0 : dot(va, vb), mute});
   endtask

   task automatic take(input int hold);
      logic [63:0] d0;
      exp_t x;
      out_ready = 1'b0;
      d0 = out_data;
      repeat (hold) begin
         @(negedge clk);
         confere("hold_data", out_data, d0);
         confere("hold_in_ready", in_ready, 0);
         confere("hold_n_ops", n_ops, 16'(exp_ops));
      end
      confere("sb_depth", sb.size(), 1);
      if (sb.size() != 0) begin
         x = sb.pop_front();
         confere("out_data", out_data, x.d);
         confere("out_erro", out_erro, x.e);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_ops++;
      confere("in_ready_after", in_ready, 1);
      confere("out_valid_after", out_valid, 0);
      confere("n_ops", n_ops, 16'(exp_ops));
   endtask

   task automatic run(input bit gap, input int hold);
      int lat;
      load(gap);
      confere("start_t1", eng_start, 1);
      confere("in_ready_start", in_ready, 0);
      @(negedge clk);
      confere("start_single", eng_start, 0);
      lat = 1;
      while (!out_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      confere("latency", lat, mute ? 65 : 10);
      take(hold);
   endtask

   task automatic chk_reset();
      confere("rst_in_ready", in_ready, 1);
      confere("rst_out_valid", out_valid, 0);
      confere("rst_out_data", out_data, 0);
      confere("rst_out_erro", out_erro, 0);
      confere("rst_eng_start", eng_start, 0);
      confere("rst_ocupado", ocupado, 0);
      confere("rst_n_ops", n_ops, 0);
      for (int i = 0; i < 8; i++) begin
         confere("rst_eng_a", ea[i], 0);
         confere("rst_eng_b", eb[i], 0);
      end
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      out_ready = 1'b0;
      mute = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      chk_reset();
      for (int i = 0; i < 8; i++) begin va[i] = i + 1; vb[i] = i + 1; end
      run(0, 0);
      for (int i = 0; i < 8; i++) begin va[i] = 32'h8000_0000; vb[i] = 32'h7fff_ffff; end
      run(0, 0);
      confere("wrap_2p34", dot(va, vb), 64'd17179869184);
      for (int i = 0; i < 8; i++) begin va[i] = i + 1; vb[i] = i + 1; end
      run(1, 0);
      for (int i = 0; i < 8; i++) begin va[i] = $urandom; vb[i] = $urandom; end
      run(0, 5);
      for (int i = 0; i < 8; i++) begin va[i] = $urandom_range(0, 200) - 100; vb[i] = $urandom; end
      run(1, 2);
      mute = 1'b1;
      run(0, 1);
      mute = 1'b0;
      load(0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      exp_ops = 0;
      chk_reset();
      repeat (15) @(negedge clk);
      confere("no_stale_valid", out_valid, 0);
      for (int i = 0; i < 8; i++) begin va[i] = 1; vb[i] = 1; end
      run(0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
